// File: rtl/butterfly_pkg.sv
// butterfly_pkg: beat-order codes and index helpers shared by the butterfly serialiser.
package butterfly_pkg;
  localparam logic [1:0] ORDER_LINEAR = 2'd0;
  localparam logic [1:0] ORDER_ROTATE = 2'd1;
  localparam logic [1:0] ORDER_BITREV = 2'd2;
  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  // Reverses the low w bits of v; w=0 yields 0.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) if (i < w) r[w-1-i] = v[i];
    return r;
  endfunction
endpackage

// File: rtl/butterfly_p2s_sched.sv
// butterfly_p2s_sched: beat/rotation counters and beat-to-group order mapping for the serialiser.
module butterfly_p2s_sched
  import butterfly_pkg::*;
#(
  parameter int NB = 8,
  localparam int LG = log2(NB),
  localparam int BW = (LG > 0) ? LG : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [1:0]    ord_i,
  input  logic          adv_i,
  output logic [BW-1:0] grp_o,
  output logic          last_o
);
  logic [BW-1:0] beat_q, beat_d, rot_q, rot_d, off_q, off_d;
  logic [1:0]    ord_q, ord_d;
  always_comb begin
    last_o = beat_q == BW'(NB - 1);
    beat_d = load_i ? '0 : adv_i ? (last_o ? '0 : beat_q + 1'b1) : beat_q;
    ord_d  = load_i ? ord_i : ord_q;
    off_d  = load_i ? rot_q : off_q;
    rot_d  = (load_i && ord_i == ORDER_ROTATE) ? ((rot_q == BW'(NB - 1)) ? '0 : rot_q + 1'b1) : rot_q;
    grp_o  = (ord_q == ORDER_ROTATE) ? beat_q + off_q :
             (ord_q == ORDER_BITREV) ? BW'(bitrev(32'(beat_q), LG)) : beat_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      beat_q <= '0;
      rot_q  <= '0;
      off_q  <= '0;
      ord_q  <= ORDER_LINEAR;
    end else begin
      beat_q <= beat_d;
      rot_q  <= rot_d;
      off_q  <= off_d;
      ord_q  <= ord_d;
    end
endmodule

// File: rtl/butterfly_p2s_stream.sv
// butterfly_p2s_stream: vector-to-serial converter with ordered beats and a registered bypass port.
// Define BUTTERFLY_P2S_LAST_EN to add dn_serial_last marking the final beat of each vector.
module butterfly_p2s_stream
  import butterfly_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_INPUT  = 8,
  parameter int LANES_OUT  = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            by_pass,
  input  logic [1:0]                      order_sel,
  input  logic [NUM_INPUT*DATA_WIDTH-1:0] up_dat,
  input  logic                            up_vld,
  output logic                            up_rdy,
  output logic [NUM_INPUT*DATA_WIDTH-1:0] dn_parallel_dat,
  output logic                            dn_parallel_vld,
  input  logic                            dn_parallel_rdy,
  output logic [LANES_OUT*DATA_WIDTH-1:0] dn_serial_dat,
  output logic                            dn_serial_vld,
  input  logic                            dn_serial_rdy
`ifdef BUTTERFLY_P2S_LAST_EN
  , output logic                          dn_serial_last
`endif
);
  localparam int NB = NUM_INPUT / LANES_OUT;
  localparam int GW = LANES_OUT * DATA_WIDTH;
  localparam int LG = log2(NB);
  localparam int BW = (LG > 0) ? LG : 1;
  logic [NUM_INPUT*DATA_WIDTH-1:0] buf_q, buf_d, par_q, par_d;
  logic          full_q, full_d, pvld_q, pvld_d;
  logic          s_xfer, s_load, p_load, up_xfer, last;
  logic [BW-1:0] grp;
  butterfly_p2s_sched #(.NB(NB)) u_sched (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (s_load),
    .ord_i  (order_sel),
    .adv_i  (s_xfer),
    .grp_o  (grp),
    .last_o (last)
  );
  // Each path waits for the other to drain so output order follows input order.
  always_comb begin
    s_xfer          = full_q & dn_serial_rdy;
    up_rdy          = by_pass ? (!pvld_q | dn_parallel_rdy) & !full_q
                              : (!full_q | (s_xfer & last)) & !pvld_q;
    up_xfer         = up_vld & up_rdy;
    s_load          = up_xfer & !by_pass;
    p_load          = up_xfer & by_pass;
    buf_d           = s_load ? up_dat : buf_q;
    full_d          = s_load | (full_q & !(s_xfer & last));
    par_d           = p_load ? up_dat : par_q;
    pvld_d          = p_load | (pvld_q & !dn_parallel_rdy);
    dn_serial_dat   = buf_q[int'(grp)*GW +: GW];
    dn_serial_vld   = full_q;
    dn_parallel_dat = par_q;
    dn_parallel_vld = pvld_q;
  end
`ifdef BUTTERFLY_P2S_LAST_EN
  assign dn_serial_last = full_q & last;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      buf_q  <= '0;
      full_q <= 1'b0;
      par_q  <= '0;
      pvld_q <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      full_q <= full_d;
      par_q  <= par_d;
      pvld_q <= pvld_d;
    end
endmodule

// File: tb/tb_butterfly_p2s_stream.sv
// tb_butterfly_p2s_stream: directed checks of beat order, backpressure, bypass ordering and reset.
module tb_butterfly_p2s_stream;
  logic         clk = 1'b0;
  logic         rst_n, rst2_n, by_pass, up_vld, up_rdy, pvld, prdy, svld, srdy;
  logic         up_vld2, up_rdy2, pvld2, svld2;
  logic [1:0]   order_sel;
  logic [127:0] up_dat, pdat, up_dat2, pdat2, e2;
  logic [15:0]  sdat;
  logic [31:0]  sdat2;
`ifdef BUTTERFLY_P2S_LAST_EN
  logic         last1, last2;
`endif
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  butterfly_p2s_stream u8 (
    .clk(clk), .rst_n(rst_n), .by_pass(by_pass), .order_sel(order_sel),
    .up_dat(up_dat), .up_vld(up_vld), .up_rdy(up_rdy),
    .dn_parallel_dat(pdat), .dn_parallel_vld(pvld), .dn_parallel_rdy(prdy),
    .dn_serial_dat(sdat), .dn_serial_vld(svld), .dn_serial_rdy(srdy)
`ifdef BUTTERFLY_P2S_LAST_EN
    , .dn_serial_last(last1)
`endif
  );
  butterfly_p2s_stream #(.LANES_OUT(2)) u2 (
    .clk(clk), .rst_n(rst2_n), .by_pass(1'b0), .order_sel(2'd0),
    .up_dat(up_dat2), .up_vld(up_vld2), .up_rdy(up_rdy2),
    .dn_parallel_dat(pdat2), .dn_parallel_vld(pvld2), .dn_parallel_rdy(1'b1),
    .dn_serial_dat(sdat2), .dn_serial_vld(svld2), .dn_serial_rdy(1'b1)
`ifdef BUTTERFLY_P2S_LAST_EN
    , .dn_serial_last(last2)
`endif
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] vec(input logic [15:0] base);
    logic [127:0] v;
    for (int i = 0; i < 8; i++) v[i*16 +: 16] = base + 16'(i);
    return v;
  endfunction
  function automatic logic [31:0] rot_seq(input int k);
    logic [31:0] s;
    for (int b = 0; b < 8; b++) s[b*4 +: 4] = 4'((b + k) % 8);
    return s;
  endfunction
  task automatic push(input logic [1:0] ord, input logic bp, input logic [15:0] base);
    int n;
    n = 0;
    order_sel = ord;
    by_pass   = bp;
    up_dat    = vec(base);
    up_vld    = 1'b1;
    #1;
    while (!up_rdy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("push_rdy", up_rdy, 1);
    @(negedge clk);
    up_vld = 1'b0;
  endtask
  task automatic expect_seq(input logic [15:0] base, input logic [31:0] seq, input int from, input int to);
    for (int b = from; b <= to; b++) begin
      chk($sformatf("vld_b%0d", b), svld, 1);
      chk($sformatf("dat_b%0d", b), sdat, base + 16'(seq[b*4 +: 4]));
      @(negedge clk);
    end
  endtask
  initial begin
    rst_n = 0; rst2_n = 0; by_pass = 0; order_sel = 0; up_dat = '0; up_vld = 0;
    up_dat2 = '0; up_vld2 = 0; srdy = 1; prdy = 0;
    repeat (2) @(negedge clk);
    rst_n = 1; rst2_n = 1;
    @(negedge clk);
    chk("rst_up_rdy", up_rdy, 1);
    chk("rst_svld", svld, 0);
    chk("rst_sdat", sdat, 0);
    chk("rst_pvld", pvld, 0);
    chk("rst_pdat", pdat, 0);
    chk("rst_pvld2", pvld2, 0);
`ifdef BUTTERFLY_P2S_LAST_EN
    chk("rst_last", last1, 0);
`endif
    push(2'd0, 1'b0, 16'h10);
    expect_seq(16'h10, 32'h76543210, 0, 7);
    chk("lin_idle", svld, 0);
    push(2'd2, 1'b0, 16'h20);
    expect_seq(16'h20, 32'h73516240, 0, 7);
    push(2'd1, 1'b0, 16'h30);
    expect_seq(16'h30, 32'h76543210, 0, 7);
    push(2'd1, 1'b0, 16'h30);
    expect_seq(16'h30, 32'h07654321, 0, 7);
    for (int k = 2; k < 8; k++) begin
      push(2'd1, 1'b0, 16'h30);
      expect_seq(16'h30, rot_seq(k), 0, 7);
    end
    push(2'd1, 1'b0, 16'h40);
    expect_seq(16'h40, 32'h76543210, 0, 7);
    // Backpressure after beat 2
    push(2'd0, 1'b0, 16'h50);
    expect_seq(16'h50, 32'h76543210, 0, 2);
    srdy = 0;
    repeat (3) begin
      chk("bp_vld", svld, 1);
      chk("bp_dat", sdat, 16'h53);
      chk("bp_up_rdy", up_rdy, 0);
      @(negedge clk);
    end
    srdy = 1;
    expect_seq(16'h50, 32'h76543210, 3, 7);
    // Streaming two vectors with up_vld held
    order_sel = 0; by_pass = 0; up_dat = vec(16'h60); up_vld = 1;
    #1;
    chk("str_rdy0", up_rdy, 1);
    @(negedge clk);
    up_dat = vec(16'h70);
    #1;
    for (int b = 0; b < 8; b++) begin
      chk("strA_vld", svld, 1);
      chk("strA_dat", sdat, 16'h60 + 16'(b));
      chk("strA_rdy", up_rdy, (b == 7));
      @(negedge clk);
    end
    up_vld = 0;
    for (int b = 0; b < 8; b++) begin
      chk("strB_vld", svld, 1);
      chk("strB_dat", sdat, 16'h70 + 16'(b));
      chk("strB_rdy", up_rdy, (b == 7));
      @(negedge clk);
    end
    chk("str_idle", svld, 0);
    // Bypass vector waits behind serial vector in flight
    push(2'd0, 1'b0, 16'h80);
    by_pass = 1; up_dat = vec(16'h90); up_vld = 1; prdy = 0;
    #1;
    for (int b = 0; b < 8; b++) begin
      chk("byp_wait_rdy", up_rdy, 0);
      chk("byp_sdat", sdat, 16'h80 + 16'(b));
      chk("byp_pvld0", pvld, 0);
      @(negedge clk);
    end
    chk("byp_sidle", svld, 0);
    chk("byp_rdy", up_rdy, 1);
    @(negedge clk);
    up_vld = 0;
    repeat (3) begin
      chk("byp_pvld", pvld, 1);
      chk("byp_pdat", pdat, vec(16'h90));
      chk("byp_hold_rdy", up_rdy, 0);
      chk("byp_svld", svld, 0);
      @(negedge clk);
    end
    prdy = 1;
    #1;
    chk("byp_drain_rdy", up_rdy, 1);
    @(negedge clk);
    chk("byp_pvld_drop", pvld, 0);
    prdy = 0; by_pass = 0;
    // Two lanes per beat
    e2 = {32'h00270026, 32'h00250024, 32'h00230022, 32'h00210020};
    up_dat2 = vec(16'h20); up_vld2 = 1;
    #1;
    chk("l2_rdy", up_rdy2, 1);
    @(negedge clk);
    up_vld2 = 0;
    for (int b = 0; b < 4; b++) begin
      chk("l2_vld", svld2, 1);
      chk("l2_dat", sdat2, e2[b*32 +: 32]);
`ifdef BUTTERFLY_P2S_LAST_EN
      chk("l2_last", last2, (b == 3));
`endif
      @(negedge clk);
    end
    chk("l2_idle", svld2, 0);
    up_dat2 = vec(16'h30); up_vld2 = 1;
    @(negedge clk);
    up_vld2 = 0;
    chk("rs_b0", sdat2, 32'h00310030);
    @(negedge clk);
    chk("rs_b1", sdat2, 32'h00330032);
    @(negedge clk);
    chk("rs_b2", sdat2, 32'h00350034);
    rst2_n = 0;
    #1;
    chk("rs_vld_drop", svld2, 0);
    @(negedge clk);
    rst2_n = 1;
    repeat (3) begin
      chk("rs_no_partial", svld2, 0);
      chk("rs_up_rdy", up_rdy2, 1);
      @(negedge clk);
    end
    e2 = {32'h00470046, 32'h00450044, 32'h00430042, 32'h00410040};
    up_dat2 = vec(16'h40); up_vld2 = 1;
    @(negedge clk);
    up_vld2 = 0;
    for (int b = 0; b < 4; b++) begin
      chk("rs_new_vld", svld2, 1);
      chk("rs_new_dat", sdat2, e2[b*32 +: 32]);
      @(negedge clk);
    end
    chk("rs_new_idle", svld2, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
